// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Optional feature macro: PERF_COUNTERS_EN enables the cycle and retired-instruction counters.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        alu_src_imm_o,
  output logic        mem_to_reg_o,
  output logic        instr_done_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [2:0]  state_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
);

  // Handshake: a memory request (mem_read_o/mem_write_o) stays asserted every
  // cycle until the cycle in which mem_ready_i=1; that cycle completes the transfer.

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t        state;
  logic [6:0]    op_q;
  logic [CW-1:0] to_cnt;
  logic [CW-1:0] to_inc;
  logic          illegal_q;
  logic          bus_err_q;
  logic          op_legal;
  logic          op_is_mem;

  // Saturating increment: the count never wraps past the limit.
  assign to_inc    = (to_cnt == LIMIT) ? to_cnt : to_cnt + CW'(1);
  assign op_legal  = (opcode_i == OP_R) || (opcode_i == OP_I) || (opcode_i == OP_U) ||
                     (opcode_i == OP_S) || (opcode_i == OP_LOAD);
  assign op_is_mem = (op_q == OP_S) || (op_q == OP_LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      to_cnt    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      to_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready_i) begin
            state <= S_DECODE;
          end else if (to_inc == LIMIT) begin
            state     <= S_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            to_cnt <= to_inc;
          end
        end
        S_DECODE: begin
          op_q <= opcode_i;
          if (op_legal) begin
            state <= S_EXECUTE;
          end else begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXECUTE: state <= op_is_mem ? S_MEMORY : S_WRITEBACK;
        S_MEMORY: begin
          if (mem_ready_i) begin
            state <= (op_q == OP_LOAD) ? S_WRITEBACK : S_FETCH;
          end else if (to_inc == LIMIT) begin
            state     <= S_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            to_cnt <= to_inc;
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_TRAP;
      endcase
    end
  end

  // Store retirement depends on mem_ready_i so the pulse stays one cycle wide under wait states.
  always_comb begin
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_imm_o = 1'b0;
    mem_to_reg_o  = 1'b0;
    instr_done_o  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_o = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
      end
      S_EXECUTE: alu_src_imm_o = (op_q != OP_R);
      S_MEMORY: begin
        alu_src_imm_o = 1'b1;
        mem_read_o    = (op_q == OP_LOAD);
        mem_write_o   = (op_q == OP_S);
        instr_done_o  = (op_q == OP_S) && mem_ready_i;
      end
      S_WRITEBACK: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (op_q == OP_LOAD);
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  assign state_o   = state;

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;
  logic        active;

  assign active = (state != S_IDLE) && (state != S_TRAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (active)       cycle_q   <= cycle_q + 32'd1;
      if (instr_done_o) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;
`else
  assign cycle_cnt_o = 32'h0;
  assign instret_o   = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle expected outputs queued with stimulus.
// Counter expectations follow the PERF_COUNTERS_EN build option.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        ir_write_o, pc_write_o, mem_read_o, mem_write_o, reg_write_o;
  logic        alu_src_imm_o, mem_to_reg_o, instr_done_o, illegal_o, bus_err_o;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt_o, instret_o;

  int total = 0;
  int bad = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXE = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_IRW  = 10'b1000000000;
  localparam logic [9:0] F_PCW  = 10'b0100000000;
  localparam logic [9:0] F_RD   = 10'b0010000000;
  localparam logic [9:0] F_WR   = 10'b0001000000;
  localparam logic [9:0] F_RW   = 10'b0000100000;
  localparam logic [9:0] F_ALU  = 10'b0000010000;
  localparam logic [9:0] F_M2R  = 10'b0000001000;
  localparam logic [9:0] F_DONE = 10'b0000000100;
  localparam logic [9:0] F_ILL  = 10'b0000000010;
  localparam logic [9:0] F_BERR = 10'b0000000001;
  localparam logic [9:0] F_FOK  = F_IRW | F_PCW | F_RD;

`ifdef PERF_COUNTERS_EN
  localparam logic [31:0] EXP_CYC = 32'd12;
  localparam logic [31:0] EXP_RET = 32'd3;
`else
  localparam logic [31:0] EXP_CYC = 32'd0;
  localparam logic [31:0] EXP_RET = 32'd0;
`endif

  logic [12:0] exp_q[$];
  logic        rdy_q[$];

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .alu_src_imm_o(alu_src_imm_o),
    .mem_to_reg_o(mem_to_reg_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o), .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] observed();
    return {state_o, ir_write_o, pc_write_o, mem_read_o, mem_write_o, reg_write_o,
            alu_src_imm_o, mem_to_reg_o, instr_done_o, illegal_o, bus_err_o};
  endfunction

  function automatic logic rnd();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // driver: one cycle of stimulus plus its expected output vector
  task automatic push(input logic rdy, input logic [2:0] st, input logic [9:0] f);
    rdy_q.push_back(rdy);
    exp_q.push_back({st, f});
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b0;
    mem_ready_i = 1'b1;
    opcode_i = OP_R;
    repeat (2) @(negedge clk);
    got = observed();
    total++;
    if (got !== 13'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", got, 13'b0);
    end
    total++;
    if (cycle_cnt_o !== 32'h0 || instret_o !== 32'h0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt_o, instret_o);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_exec_types();
    logic [6:0]  ops [3] = '{OP_R, OP_I, OP_U};
    logic [9:0]  alu [3] = '{F_NONE, F_ALU, F_ALU};
    logic [12:0] e, got;
    int n;
    for (int k = 0; k < 3; k++) begin
      opcode_i = ops[k];
      apply_reset();
      push(rnd(), ST_IDLE, F_NONE);
      push(1'b1,  ST_FETCH, F_FOK);
      push(rnd(), ST_DEC, F_NONE);
      push(rnd(), ST_EXE, alu[k]);
      push(rnd(), ST_WB, F_RW | F_DONE);
      push(1'b1,  ST_FETCH, F_FOK);
      push(rnd(), ST_DEC, F_NONE);
      n = 0;
      while (exp_q.size() > 0) begin
        mem_ready_i = rdy_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        got = observed();
        total++;
        if (got !== e) begin
          bad++; $display("FAIL exec_op%0d cyc=%0d got=%b exp=%b", k, n, got, e);
        end
        n++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load_wait();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_LOAD;
    apply_reset();
    push(rnd(), ST_IDLE, F_NONE);
    push(1'b1,  ST_FETCH, F_FOK);
    push(rnd(), ST_DEC, F_NONE);
    push(rnd(), ST_EXE, F_ALU);
    repeat (3) push(1'b0, ST_MEM, F_RD | F_ALU);
    push(1'b1,  ST_MEM, F_RD | F_ALU);
    push(rnd(), ST_WB, F_RW | F_M2R | F_DONE);
    push(1'b1,  ST_FETCH, F_FOK);
    n = 0;
    while (exp_q.size() > 0) begin
      mem_ready_i = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL load_wait cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_store();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_S;
    apply_reset();
    push(rnd(), ST_IDLE, F_NONE);
    push(1'b1,  ST_FETCH, F_FOK);
    push(rnd(), ST_DEC, F_NONE);
    push(rnd(), ST_EXE, F_ALU);
    push(1'b1,  ST_MEM, F_WR | F_ALU | F_DONE);
    push(1'b1,  ST_FETCH, F_FOK);
    push(rnd(), ST_DEC, F_NONE);
    push(rnd(), ST_EXE, F_ALU);
    push(1'b0,  ST_MEM, F_WR | F_ALU);
    push(1'b0,  ST_MEM, F_WR | F_ALU);
    push(1'b1,  ST_MEM, F_WR | F_ALU | F_DONE);
    push(1'b0,  ST_FETCH, F_RD);
    n = 0;
    while (exp_q.size() > 0) begin
      mem_ready_i = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL store cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_BAD;
    apply_reset();
    push(rnd(), ST_IDLE, F_NONE);
    push(1'b1,  ST_FETCH, F_FOK);
    push(rnd(), ST_DEC, F_NONE);
    repeat (21) push(rnd(), ST_TRAP, F_ILL);
    n = 0;
    while (exp_q.size() > 0) begin
      mem_ready_i = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL illegal cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #2;
    total++;
    if (state_o !== ST_IDLE || illegal_o !== 1'b0) begin
      bad++; $display("FAIL illegal_reset got=%0d/%b exp=0/0", state_o, illegal_o);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_fetch_timeout();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_R;
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      push(rnd(), ST_IDLE, F_NONE);
      repeat (14) push(1'b0, ST_FETCH, F_RD);
      if (pass == 0) begin
        push(1'b0, ST_FETCH, F_RD);
        repeat (3) push(rnd(), ST_TRAP, F_BERR);
      end else begin
        push(1'b1,  ST_FETCH, F_FOK);
        push(rnd(), ST_DEC, F_NONE);
        push(rnd(), ST_EXE, F_NONE);
      end
      n = 0;
      while (exp_q.size() > 0) begin
        mem_ready_i = rdy_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        got = observed();
        total++;
        if (got !== e) begin
          bad++; $display("FAIL fetch_timeout%0d cyc=%0d got=%b exp=%b", pass, n, got, e);
        end
        n++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_mem_timeout();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_LOAD;
    apply_reset();
    push(rnd(), ST_IDLE, F_NONE);
    repeat (10) push(1'b0, ST_FETCH, F_RD);
    push(1'b1,  ST_FETCH, F_FOK);
    push(rnd(), ST_DEC, F_NONE);
    push(rnd(), ST_EXE, F_ALU);
    repeat (15) push(1'b0, ST_MEM, F_RD | F_ALU);
    repeat (3) push(rnd(), ST_TRAP, F_BERR);
    n = 0;
    while (exp_q.size() > 0) begin
      mem_ready_i = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_S;
    apply_reset();
    push(rnd(), ST_IDLE, F_NONE);
    push(1'b1,  ST_FETCH, F_FOK);
    push(rnd(), ST_DEC, F_NONE);
    push(rnd(), ST_EXE, F_ALU);
    push(1'b0,  ST_MEM, F_WR | F_ALU);
    n = 0;
    while (exp_q.size() > 0) begin
      mem_ready_i = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL mid_store cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (mem_write_o !== 1'b1) begin
      bad++; $display("FAIL mid_store_pre got=%b exp=1", mem_write_o);
    end
    reset = 1'b0;
    #1;
    total++;
    if (mem_write_o !== 1'b0 || state_o !== ST_IDLE) begin
      bad++; $display("FAIL async_reset got=%b/%0d exp=0/0", mem_write_o, state_o);
    end
    repeat (2) @(negedge clk);
    got = observed();
    total++;
    if (got !== 13'b0) begin
      bad++; $display("FAIL held_reset got=%b exp=%b", got, 13'b0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_perf_counters();
    logic [12:0] e, got;
    int n;
    opcode_i = OP_R;
    apply_reset();
    push(rnd(), ST_IDLE, F_NONE);
    repeat (3) begin
      push(1'b1,  ST_FETCH, F_FOK);
      push(rnd(), ST_DEC, F_NONE);
      push(rnd(), ST_EXE, F_NONE);
      push(rnd(), ST_WB, F_RW | F_DONE);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      mem_ready_i = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL perf_seq cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (cycle_cnt_o !== EXP_CYC) begin
      bad++; $display("FAIL cycle_cnt got=%0d exp=%0d", cycle_cnt_o, EXP_CYC);
    end
    total++;
    if (instret_o !== EXP_RET) begin
      bad++; $display("FAIL instret got=%0d exp=%0d", instret_o, EXP_RET);
    end
  endtask

  initial begin
    test_reset();
    test_exec_types();
    test_load_wait();
    test_back_to_back_store();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_store();
    test_perf_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
